// File: rtl/dmem_if.sv
// Data-memory request/response channel: the core is the master, the memory-side
// responder is the slave. Both directions use valid/ready handshakes.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_rsel;
    logic [1:0]  req_wsel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_rsel, req_wsel, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_rsel, req_wsel, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port with WAIT_CYCLES wait states per access.
// Define DMEM_RESP_PIPE_EN to accept the next request on the same edge as the response handshake.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);
    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        NO_WAIT    = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        alive_q, alive_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rsel_q, rsel_d;
    logic [1:0]  wsel_q, wsel_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req_ready_c;
    logic        accept;
    logic        direct;
    logic        do_access;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [2:0]  a_rsel;
    logic [1:0]  a_wsel;
    logic [AW-1:0] a_idx;
    logic        a_err;
    logic [31:0] a_word;
    logic [31:0] a_rdata;
    logic [3:0]  a_mask;
    logic [31:0] a_lanes;
    logic        mem_we;

    function automatic logic req_fault(input logic        we,
                                       input logic [31:0] addr,
                                       input logic [2:0]  rsel,
                                       input logic [1:0]  wsel);
        logic half;
        logic word;
        logic bad_size;
        if (we) begin
            half     = (wsel == 2'b01);
            word     = (wsel == 2'b10);
            bad_size = (wsel == 2'b11);
        end else begin
            half     = (rsel[1:0] == 2'b01);
            word     = (rsel == 3'b010);
            bad_size = (rsel == 3'b011) || (rsel[2:1] == 2'b11);
        end
        return bad_size || (half && addr[0]) || (word && (addr[1:0] != 2'b00)) ||
               ({1'b0, addr} >= BYTE_LIMIT);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  rsel);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? word[31:16] : word[15:0];
        case (rsel)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] off, input logic [1:0] wsel);
        case (wsel)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] wsel);
        case (wsel)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // alive_q holds req_ready low until the first edge after reset release.
    always_comb begin
        alive_d     = 1'b1;
        req_ready_c = 1'b0;
        if (alive_q) begin
            if (state_q == S_IDLE) begin
                req_ready_c = 1'b1;
            end
`ifdef DMEM_RESP_PIPE_EN
            else if (state_q == S_RESP) begin
                req_ready_c = bus.rsp_ready;
            end
`endif
        end
    end

    assign accept = bus.req_valid && req_ready_c;
    // With no wait states the access happens on the accept edge, straight from the bus.
    assign direct = accept && NO_WAIT;

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsel_d  = rsel_q;
        wsel_d  = wsel_q;
        if (accept) begin
            we_d    = bus.req_we;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            rsel_d  = bus.req_rsel;
            wsel_d  = bus.req_wsel;
        end
    end

    always_comb begin
        a_we      = direct ? bus.req_we    : we_q;
        a_addr    = direct ? bus.req_addr  : addr_q;
        a_wdata   = direct ? bus.req_wdata : wdata_q;
        a_rsel    = direct ? bus.req_rsel  : rsel_q;
        a_wsel    = direct ? bus.req_wsel  : wsel_q;
        do_access = direct || ((state_q == S_WAIT) && (cnt_q == 4'd0));
        a_idx     = a_addr[AW+1:2];
        a_err     = req_fault(a_we, a_addr, a_rsel, a_wsel);
        a_word    = mem[a_idx];
        a_rdata   = (a_err || a_we) ? 32'd0 : load_extract(a_word, a_addr[1:0], a_rsel);
        a_mask    = store_mask(a_addr[1:0], a_wsel);
        a_lanes   = store_lanes(a_wdata, a_wsel);
        mem_we    = do_access && a_we && !a_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = NO_WAIT ? S_RESP : S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
`ifdef DMEM_RESP_PIPE_EN
                    if (accept) begin
                        state_d = NO_WAIT ? S_RESP : S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_access) begin
            rdata_d = a_rdata;
            err_d   = a_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            alive_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rsel_q  <= rsel_d;
        wsel_q  <= wsel_d;
    end

    // Stores commit on the edge that enters RESP; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    mem[a_idx][8*i +: 8] <= a_lanes[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
